// File: rtl/pmp_pkg.sv
// Shared definitions for the pattern-matching engine: channel count default,
// command opcodes, control-word field positions and the pattern/history width.
// No ports (package).
package pmp_pkg;

  localparam int NUM_MODULES_DEF = 4;

  localparam int PAT_BYTES = 8;
  localparam int PAT_W     = 8 * PAT_BYTES;

  localparam int CTRL_W    = 16;
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 14;
  localparam int CNT_MSB   = 13;
  localparam int CNT_LSB   = 11;
  localparam int CNT_W     = CNT_MSB - CNT_LSB + 1;
  localparam int RSVD_MSB  = 10;

  localparam int READY_W   = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_MATCH = 2'b10,
    OP_CLEAR = 2'b11
  } pmp_op_e;

  // Mask keeping bytes 0..cnt_m1 of a word; used so a stored pattern never
  // carries stale bytes beyond its length.
  function automatic logic [PAT_W-1:0] byte_mask(input logic [CNT_W-1:0] cnt_m1);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int k = 0; k < PAT_BYTES; k++) begin
      if (k <= int'(cnt_m1)) m[8*k +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/pmp_matcher.sv
// One pattern-matching channel: four-phase handshake, pattern store, 8-byte
// history shift register and comparator.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   data              64-bit command word (byte 0 = bits [7:0])
//   control           16-bit command (opcode, byte count - 1)
//   data_ready        command pending
//   data_accepted     command finished (held while data_ready stays high)
//   pattern_accepted  sticky match flag, cleared by LOAD/CLEAR/reset
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for data_ready with data_accepted low
// BUSY    | command latched; MATCH shifts one byte per clock, then completes
// DONE    | data_accepted high, waiting for data_ready to drop
module pmp_matcher
  import pmp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [PAT_W-1:0]  data,
  input  logic [CTRL_W-1:0] control,
  input  logic              data_ready,
  output logic              data_accepted,
  output logic              pattern_accepted
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  pmp_op_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PAT_W-1:0] word_q;
  logic [3:0]       byte_ctr;

  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] pat_len_m1;
  logic             pat_valid;
  logic [PAT_W-1:0] hist_q;
  logic [3:0]       hist_cnt;

  logic [7:0]       byte_in;
  logic [PAT_W-1:0] hist_nxt;
  logic [3:0]       hist_cnt_nxt;
  logic             hit;

  pmp_op_e          op_in;
  logic [CNT_W-1:0] cnt_in;
  logic             unused_ctrl;

  assign op_in       = pmp_op_e'(control[OP_MSB:OP_LSB]);
  assign cnt_in      = control[CNT_MSB:CNT_LSB];
  assign unused_ctrl = ^control[RSVD_MSB:0];

  // The latched word is shifted right as bytes are consumed, so the next
  // byte to stream is always the low byte.
  assign byte_in      = word_q[7:0];
  // History: byte 0 is the newest byte, byte j is j bytes older.
  assign hist_nxt     = {hist_q[PAT_W-9:0], byte_in};
  assign hist_cnt_nxt = (hist_cnt == 4'(PAT_BYTES)) ? hist_cnt : hist_cnt + 4'd1;

  // Match against the history as it will be after this byte is shifted in.
  // Pattern byte 0 is the oldest of the last L bytes, i.e. history byte L-1.
  always_comb begin
    hit = pat_valid && (hist_cnt_nxt > {1'b0, pat_len_m1});
    for (int j = 0; j < PAT_BYTES; j++) begin
      if (j <= int'(pat_len_m1)) begin
        if (hist_nxt[8*j +: 8] != pat_q[8*(int'(pat_len_m1) - j) +: 8]) hit = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      op_q             <= OP_NOP;
      cnt_q            <= '0;
      word_q           <= '0;
      byte_ctr         <= '0;
      pat_q            <= '0;
      pat_len_m1       <= '0;
      pat_valid        <= 1'b0;
      hist_q           <= '0;
      hist_cnt         <= '0;
      data_accepted    <= 1'b0;
      pattern_accepted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_ready && !data_accepted) begin
            op_q     <= op_in;
            cnt_q    <= cnt_in;
            word_q   <= data;
            // Down-counter of bytes still to stream; zero means the next
            // edge completes the command.
            byte_ctr <= (op_in == OP_MATCH) ? ({1'b0, cnt_in} + 4'd1) : 4'd0;
            state    <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (byte_ctr != 4'd0) begin
            hist_q   <= hist_nxt;
            hist_cnt <= hist_cnt_nxt;
            word_q   <= word_q >> 8;
            byte_ctr <= byte_ctr - 4'd1;
            if (hit) pattern_accepted <= 1'b1;
          end else begin
            case (op_q)
              OP_LOAD: begin
                pat_q            <= word_q & byte_mask(cnt_q);
                pat_len_m1       <= cnt_q;
                pat_valid        <= 1'b1;
                hist_q           <= '0;
                hist_cnt         <= '0;
                pattern_accepted <= 1'b0;
              end
              OP_CLEAR: begin
                pat_valid        <= 1'b0;
                hist_q           <= '0;
                hist_cnt         <= '0;
                pattern_accepted <= 1'b0;
              end
              default: ;
            endcase
            // If the requester already withdrew, skip the acknowledge.
            data_accepted <= data_ready;
            state         <= data_ready ? ST_DONE : ST_IDLE;
          end
        end

        ST_DONE: begin
          if (!data_ready) begin
            data_accepted <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pmp_match_engine.sv
// Multi-channel byte-pattern matching engine: NUM_MODULES independent
// pmp_matcher channels sharing one clock and reset.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   data[i]           64-bit word for channel i (entry NUM_MODULES unused)
//   control[i]        16-bit command for channel i (entry NUM_MODULES unused)
//   data_ready        bit i = command pending on channel i
//   data_accepted     bit i = channel i finished its command
//   pattern_accepted  bit i = channel i found its pattern (sticky)
// NUM_MODULES must be between 1 and 32; output bits above it read 0.
module pmp_match_engine
  import pmp_pkg::*;
#(
  parameter int NUM_MODULES = NUM_MODULES_DEF
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PAT_W-1:0]   data    [0:NUM_MODULES],
  input  logic [CTRL_W-1:0]  control [0:NUM_MODULES],
  input  logic [READY_W-1:0] data_ready,
  output logic [READY_W-1:0] data_accepted,
  output logic [READY_W-1:0] pattern_accepted
);

  logic da_ch [NUM_MODULES];
  logic pa_ch [NUM_MODULES];
  logic unused_inputs;

  // The extra array entry and the upper ready bits have no channel behind them.
  assign unused_inputs = ^{data[NUM_MODULES], control[NUM_MODULES], data_ready};

  for (genvar i = 0; i < NUM_MODULES; i++) begin : g_ch
    pmp_matcher u_matcher (
      .clk              (clk),
      .reset            (reset),
      .data             (data[i]),
      .control          (control[i]),
      .data_ready       (data_ready[i]),
      .data_accepted    (da_ch[i]),
      .pattern_accepted (pa_ch[i])
    );
  end

  always_comb begin
    data_accepted    = '0;
    pattern_accepted = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      data_accepted[i]    = da_ch[i];
      pattern_accepted[i] = pa_ch[i];
    end
  end

endmodule

// File: tb/tb_pmp_match_engine.sv
module tb_pmp_match_engine;
  import pmp_pkg::*;

  localparam int NM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data    [0:NM];
  logic [15:0] control [0:NM];
  logic [31:0] data_ready = '0;
  logic [31:0] data_accepted;
  logic [31:0] pattern_accepted;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pmp_match_engine #(.NUM_MODULES(NM)) dut (
    .clk              (clk),
    .reset            (reset),
    .data             (data),
    .control          (control),
    .data_ready       (data_ready),
    .data_accepted    (data_accepted),
    .pattern_accepted (pattern_accepted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per channel: edges left until completion (0 = not busy), acknowledge
  // flag, sticky match flag, pattern bytes, and history kept oldest-first.
  int          m_left [NM];
  bit          m_acc  [NM];
  bit          m_pa   [NM];
  bit          m_valid[NM];
  logic [7:0]  m_pat  [NM][8];
  int          m_len  [NM];
  logic [7:0]  m_hist [NM][8];
  int          m_nh   [NM];
  logic [1:0]  m_op   [NM];
  int          m_n    [NM];
  logic [63:0] m_word [NM];

  task automatic push_byte(input int c, input logic [7:0] b);
    if (m_nh[c] == 8) begin
      for (int k = 0; k < 7; k++) m_hist[c][k] = m_hist[c][k+1];
      m_hist[c][7] = b;
    end else begin
      m_hist[c][m_nh[c]] = b;
      m_nh[c]++;
    end
  endtask

  function automatic bit model_hit(input int c);
    if (!m_valid[c] || m_nh[c] < m_len[c]) return 1'b0;
    for (int k = 0; k < m_len[c]; k++)
      if (m_hist[c][m_nh[c] - m_len[c] + k] != m_pat[c][k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int idx;
    if (reset) begin
      for (int c = 0; c < NM; c++) begin
        m_left[c] = 0; m_acc[c] = 0; m_pa[c] = 0; m_valid[c] = 0; m_nh[c] = 0; m_len[c] = 0;
      end
      return;
    end
    for (int c = 0; c < NM; c++) begin
      if (m_left[c] == 0 && !m_acc[c]) begin
        if (data_ready[c]) begin
          m_op[c]   = control[c][15:14];
          m_n[c]    = int'(control[c][13:11]) + 1;
          m_word[c] = data[c];
          m_left[c] = (m_op[c] == 2'b10) ? m_n[c] + 1 : 1;
        end
      end else if (m_left[c] > 0) begin
        m_left[c]--;
        if (m_left[c] > 0) begin
          idx = m_n[c] - m_left[c];
          push_byte(c, m_word[c][8*idx +: 8]);
          if (model_hit(c)) m_pa[c] = 1'b1;
        end else begin
          if (m_op[c] == 2'b01) begin
            for (int k = 0; k < 8; k++) m_pat[c][k] = m_word[c][8*k +: 8];
            m_len[c] = m_n[c]; m_valid[c] = 1; m_nh[c] = 0; m_pa[c] = 0;
          end else if (m_op[c] == 2'b11) begin
            m_valid[c] = 0; m_nh[c] = 0; m_pa[c] = 0;
          end
          m_acc[c] = data_ready[c];
        end
      end else if (!data_ready[c]) begin
        m_acc[c] = 0;
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NM; c++) begin
      m_left[c] = 0; m_acc[c] = 0; m_pa[c] = 0; m_valid[c] = 0; m_nh[c] = 0; m_len[c] = 0;
    end
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  always @(negedge clk) begin : cmp
    logic [31:0] e_da, e_pa;
    e_da = '0;
    e_pa = '0;
    for (int c = 0; c < NM; c++) begin
      e_da[c] = m_acc[c];
      e_pa[c] = m_pa[c];
    end
    check("model data_accepted", data_accepted, e_da);
    check("model pattern_accepted", pattern_accepted, e_pa);
  end

  // ---------------- stimulus ----------------
  task automatic run_cmd(input int ch, input logic [15:0] ctl, input logic [63:0] d,
                         input int exp_lat, input bit scribble, input string name);
    int edges;
    bit seen;
    @(negedge clk);
    control[ch] = ctl; data[ch] = d; data_ready[ch] = 1'b1;
    edges = 0; seen = 0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (scribble && edges == 1) begin
        data[ch] = ~d; control[ch] = 16'hC000;
      end
      if (data_accepted[ch]) seen = 1;
    end
    check({name, " latency"}, 32'(edges - 1), 32'(exp_lat));
    data_ready[ch] = 1'b0;
    @(negedge clk);
    check({name, " ack drop"}, {31'b0, data_accepted[ch]}, 32'd0);
  endtask

  task automatic run_all(input logic [15:0] ctl [NM], input logic [63:0] d [NM], input string name);
    int cyc;
    @(negedge clk);
    for (int c = 0; c < NM; c++) begin
      control[c] = ctl[c]; data[c] = d[c];
    end
    data_ready = 32'hA5A5_A5AF;
    cyc = 0;
    while (data_accepted[NM-1:0] != 4'hF && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " all acked"}, {28'b0, data_accepted[NM-1:0]}, 32'h0000_000F);
    data_ready = '0;
    @(negedge clk);
  endtask

  logic [15:0] ctl4 [NM];
  logic [63:0] dat4 [NM];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c <= NM; c++) begin
      data[c] = '0; control[c] = '0;
    end
    data[NM] = '1; control[NM] = 16'hFFFF;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data_accepted", data_accepted, 32'd0);
    check("reset pattern_accepted", pattern_accepted, 32'd0);
    reset = 1'b0;

    // ready bits beyond the channel count must do nothing
    data_ready = 32'hFFFF_FFF0;
    repeat (4) @(negedge clk);
    check("upper ready ignored", data_accepted, 32'd0);
    data_ready = '0;

    run_cmd(0, 16'h4800, 64'h4241, 1, 0, "load ch0");
    check("load ch0 no match", pattern_accepted, 32'd0);
    run_cmd(0, 16'h0000, 64'h0, 1, 0, "nop ch0");
    run_cmd(0, 16'hB800, 64'h0000_0000_0000_4241, 9, 1, "match ch0");
    check("match ch0 hit", pattern_accepted, 32'h1);

    run_cmd(1, 16'h4800, 64'h4241, 1, 0, "load ch1");
    run_cmd(1, 16'h8000, 64'h41, 2, 0, "split1 ch1");
    check("split first half", {31'b0, pattern_accepted[1]}, 32'd0);
    run_cmd(1, 16'h8000, 64'h42, 2, 0, "split2 ch1");
    check("split second half", pattern_accepted, 32'h3);

    run_cmd(0, 16'hC000, 64'h0, 1, 0, "clear ch0");
    check("clear ch0", pattern_accepted, 32'h2);
    run_cmd(0, 16'hB800, 64'h4241, 9, 0, "rematch ch0");
    check("no pattern no match", pattern_accepted, 32'h2);

    // requester withdraws before completion: no acknowledge at all
    @(negedge clk);
    control[3] = 16'h8800; data[3] = 64'h1234; data_ready[3] = 1'b1;
    @(negedge clk);
    data_ready[3] = 1'b0;
    repeat (6) @(negedge clk);
    check("early drop no ack", {31'b0, data_accepted[3]}, 32'd0);

    // reset in the middle of a MATCH
    run_cmd(2, 16'h4800, 64'h4241, 1, 0, "load ch2");
    @(negedge clk);
    control[2] = 16'hB800; data[2] = 64'h4241; data_ready[2] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    data_ready[2] = 1'b0;
    check("mid-match before reset", pattern_accepted, 32'h6);
    #2 reset = 1'b1;
    #1;
    check("reset async data_accepted", data_accepted, 32'd0);
    check("reset async pattern_accepted", pattern_accepted, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_cmd(2, 16'hB800, 64'h4241, 9, 0, "match ch2 after reset");
    check("match after reset needs load", pattern_accepted, 32'd0);

    // concurrent channels, different patterns
    ctl4[0] = 16'h4800; dat4[0] = 64'h4241;
    ctl4[1] = 16'h5000; dat4[1] = 64'h434241;
    ctl4[2] = 16'h4000; dat4[2] = 64'hAA;
    ctl4[3] = 16'h4800; dat4[3] = 64'h5566;
    run_all(ctl4, dat4, "concurrent load");
    check("concurrent load no match", pattern_accepted, 32'd0);
    ctl4[0] = 16'h8800; dat4[0] = 64'h4241;
    ctl4[1] = 16'h9000; dat4[1] = 64'h424143;
    ctl4[2] = 16'h9000; dat4[2] = 64'h00AA00;
    ctl4[3] = 16'h8800; dat4[3] = 64'h6655;
    run_all(ctl4, dat4, "concurrent match");
    check("concurrent match bits", pattern_accepted, 32'h5);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
